// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key schedule FSM states and GF(2^8) helpers.
// Used by the key schedule, its S-box instances and the cipher datapaths.
package aes_pkg;

  localparam int AES_NK         = 4;
  localparam int AES_NR         = 10;
  localparam int AES_RK_W       = 128;
  localparam int AES_FULL_KEY_W = 1408;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared between the key schedule and the encryption round logic.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key schedule: one round key per clock into 11 slots.
// Define AES_KS_REVERSE_EN to place round key 10 at the top of full_key.
module aes_key_schedule_seq
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AES_RK_W-1:0]       key_in,
  input  logic                      key_valid,
  output logic                      key_ready,
  output logic                      busy,
  output logic                      keys_valid,
  output logic [AES_FULL_KEY_W-1:0] full_key
);

  ks_state_t state, state_nx;

  logic [3:0]          rcnt;
  logic [7:0]          rcon;
  logic [AES_RK_W-1:0] rk [AES_NR+1];
  logic [AES_RK_W-1:0] prev;
  logic [AES_RK_W-1:0] nk;
  logic [31:0]         w0, w1, w2, w3;
  logic [31:0]         sub, t;
  logic [31:0]         n0, n1, n2, n3;
  logic                accept;
  logic                rcnt_ok;
  logic                last;

  assign accept  = key_valid && key_ready;
  assign rcnt_ok = (rcnt != 4'd0) && (rcnt <= 4'(AES_NR));
  assign last    = (rcnt == 4'(AES_NR));

  always_comb begin
    prev = '0;
    for (int i = 0; i < AES_NR; i++) begin
      if (rcnt == 4'(i + 1)) prev = rk[i];
    end
  end

  assign {w0, w1, w2, w3} = prev;

  // RotWord is folded into the S-box wiring
  aes_sbox u_sb0 (.a(w3[23:16]), .y(sub[31:24]));
  aes_sbox u_sb1 (.a(w3[15:8]),  .y(sub[23:16]));
  aes_sbox u_sb2 (.a(w3[7:0]),   .y(sub[15:8]));
  aes_sbox u_sb3 (.a(w3[31:24]), .y(sub[7:0]));

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign nk = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nx = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (!rcnt_ok)  state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        key_ready = 1'b1;
        if (key_valid) state_nx = EXPAND;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt       <= '0;
      rcon       <= '0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) rk[i] <= '0;
    end else if (accept) begin
      rcnt       <= 4'd1;
      rcon       <= 8'h01;
      keys_valid <= 1'b0;
      rk[0]      <= key_in;
      for (int i = 1; i <= AES_NR; i++) rk[i] <= '0;
    end else if (state == EXPAND && rcnt_ok) begin
      rcnt <= rcnt + 4'd1;
      rcon <= xtime(rcon);
      for (int i = 1; i <= AES_NR; i++) begin
        if (rcnt == 4'(i)) rk[i] <= nk;
      end
      if (last) keys_valid <= 1'b1;
    end
  end

  always_comb begin
    full_key = '0;
    for (int k = 0; k <= AES_NR; k++) begin
`ifdef AES_KS_REVERSE_EN
      full_key[AES_RK_W*k +: AES_RK_W] = rk[k];
`else
      full_key[AES_FULL_KEY_W-1-AES_RK_W*k -: AES_RK_W] = rk[k];
`endif
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq using FIPS-197 and all-zero keys.
// Honours AES_KS_REVERSE_EN when extracting round key slots from full_key.
module tb_aes_key_schedule_seq;

  logic          clk;
  logic          rst;
  logic [127:0]  key_in;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          keys_valid;
  logic [1407:0] full_key;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] k0;
    logic [127:0] k1;
    logic [127:0] k10;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K   = 128'h0;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .full_key   (full_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] slot(input int k);
`ifdef AES_KS_REVERSE_EN
    return full_key[128*k +: 128];
`else
    return full_key[1407-128*k -: 128];
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [127:0] k, input logic [127:0] e1, input logic [127:0] e10);
    exp_t e;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    e.k0 = k; e.k1 = e1; e.k10 = e10;
    sb.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("acc_kv",   {127'd0, keys_valid}, 128'd0);
    chk("acc_busy", {127'd0, busy},       128'd1);
    chk("acc_rdy",  {127'd0, key_ready},  128'd0);
    chk("acc_s0",   slot(0), k);
    chk("acc_s10",  slot(10), 128'd0);
  endtask

  task automatic expand(input int inj_at, input int rst_at);
    int   n;
    exp_t e;
    n = 0;
    while (!keys_valid && n < 20) begin
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_fk",  {127'd0, (full_key == '0)}, 128'd1);
        chk("rst_kv",  {127'd0, keys_valid}, 128'd0);
        chk("rst_rdy", {127'd0, key_ready},  128'd1);
        chk("rst_busy", {127'd0, busy},      128'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (n == inj_at) begin
        key_in    = ~FIPS_K;
        key_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      n++;
      if (!keys_valid) begin
        chk("exp_busy", {127'd0, busy},      128'd1);
        chk("exp_rdy",  {127'd0, key_ready}, 128'd0);
      end
    end
    chk("latency", 128'(n), 128'd10);
    if (sb.size() == 0) begin
      chk("sb_empty", 128'd0, 128'd1);
      return;
    end
    e = sb.pop_front();
    chk("s0",  slot(0),  e.k0);
    chk("s1",  slot(1),  e.k1);
    chk("s10", slot(10), e.k10);
    chk("done_rdy",  {127'd0, key_ready}, 128'd1);
    chk("done_busy", {127'd0, busy},      128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    #12;
    chk("r_rdy",  {127'd0, key_ready},  128'd1);
    chk("r_busy", {127'd0, busy},       128'd0);
    chk("r_kv",   {127'd0, keys_valid}, 128'd0);
    chk("r_fk",   {127'd0, (full_key == '0)}, 128'd1);
    @(negedge clk);
    rst = 1'b0;

    offer(FIPS_K, FIPS_K1, FIPS_K10);
    expand(-1, -1);
`ifdef AES_KS_REVERSE_EN
    chk("rev_top", full_key[1407:1280], FIPS_K10);
    chk("rev_bot", full_key[127:0],     FIPS_K);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("hold_kv",  {127'd0, keys_valid}, 128'd1);
    chk("hold_s10", slot(10), FIPS_K10);

    offer(ZERO_K, ZERO_K1, ZERO_K10);
    expand(4, -1);

    offer(FIPS_K, FIPS_K1, FIPS_K10);
    expand(-1, 5);
    offer(FIPS_K, FIPS_K1, FIPS_K10);
    expand(-1, -1);

    offer(ZERO_K, ZERO_K1, ZERO_K10);
    expand(-1, -1);

    chk("sb_left", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
